// File: rtl/io_map_pkg.sv
// Shared I/O address map, access-size encodings and sequencer state type
// for the board I/O access controller.
package io_map_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 16;

    localparam logic [ADDR_W-1:0] LED_ADDR  = 14'h3C60;
    localparam logic [ADDR_W-1:0] SW_ADDR   = 14'h3C70;
    localparam logic [ADDR_W-1:0] CONF_ADDR = 14'h3C80;
    localparam logic [ADDR_W-1:0] SEG_ADDR  = 14'h3C90;

    localparam logic [1:0] BW_SBYTE = 2'b00;
    localparam logic [1:0] BW_WORD  = 2'b01;
    localparam logic [1:0] BW_UBYTE = 2'b10;
    localparam logic [1:0] BW_UHALF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_DONE
    } io_state_e;

    // Widen the raw switch value according to the load size/signedness.
    function automatic logic [DATA_W-1:0] sw_extend(input logic [SW_W-1:0] sw,
                                                    input logic [1:0]      bw);
        logic [DATA_W-1:0] r;
        case (bw)
            BW_SBYTE: r = {{24{sw[7]}}, sw[7:0]};
            BW_WORD:  r = {{16{sw[15]}}, sw};
            BW_UBYTE: r = {24'b0, sw[7:0]};
            default:  r = {16'b0, sw};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Confirm-button synchronizer and debouncer; emits the clean level plus
// one-cycle strobes in the first cycle the level shows its new value.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Count consecutive cycles the synchronized input disagrees with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/io_access_ctrl.sv
// Board I/O access sequencer: confirm-gated switch reads with pipeline stall,
// confirm-status reads, and LED / seven-segment register writes.
module io_access_ctrl
    import io_map_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              io_read_i,
    input  logic              io_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        byte_or_word_i,
    input  logic              confirm_btn_i,
    input  logic [SW_W-1:0]   switch_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic [15:0]       led_o,
    output logic [DATA_W-1:0] seg_data_o,
    output logic              confirm_o
);

    io_state_e         state_q, state_d;
    logic [DATA_W-1:0] sw_data_q, sw_data_d;
    logic [15:0]       led_q, led_d;
    logic [DATA_W-1:0] seg_q, seg_d;
    logic              conf_rise, conf_fall;
    logic              wr_req, rd_req, sw_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (confirm_btn_i),
        .level_o(confirm_o),
        .rise_o (conf_rise),
        .fall_o (conf_fall)
    );

    // A simultaneous read+write is treated as a write only.
    assign wr_req = req_valid_i & io_write_i;
    assign rd_req = req_valid_i & io_read_i & ~io_write_i;
    assign sw_req = rd_req & (addr_i == SW_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sw_data_q <= '0;
            led_q     <= '0;
            seg_q     <= '0;
        end else begin
            state_q   <= state_d;
            sw_data_q <= sw_data_d;
            led_q     <= led_d;
            seg_q     <= seg_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sw_data_d     = sw_data_q;
        led_d         = led_q;
        seg_d         = seg_q;
        rdata_o       = '0;
        rdata_valid_o = 1'b0;
        stall_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sw_req) begin
                    state_d = ST_WAIT_PRESS;
                end
                if (wr_req) begin
                    if (addr_i == LED_ADDR) begin
                        if (byte_or_word_i[0]) begin
                            led_d = wdata_i[15:0];
                        end else begin
                            led_d[7:0] = wdata_i[7:0];
                        end
                    end else if (addr_i == SEG_ADDR) begin
                        case (byte_or_word_i)
                            BW_WORD:  seg_d        = wdata_i;
                            BW_UHALF: seg_d[15:0]  = wdata_i[15:0];
                            default:  seg_d[7:0]   = wdata_i[7:0];
                        endcase
                    end
                end
            end
            ST_WAIT_PRESS: begin
                if (!req_valid_i) begin
                    state_d = ST_IDLE;
                end else if (conf_rise) begin
                    sw_data_d = sw_extend(switch_i, byte_or_word_i);
                    state_d   = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!req_valid_i) begin
                    state_d = ST_IDLE;
                end else if (conf_fall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                rdata_o       = sw_data_q;
                rdata_valid_o = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Confirm-status and unmapped reads complete in the request cycle.
        if ((state_q != ST_DONE) && rd_req && !sw_req) begin
            rdata_valid_o = 1'b1;
            rdata_o       = (addr_i == CONF_ADDR) ? {31'b0, confirm_o} : '0;
        end

        stall_o = sw_req & (state_q != ST_DONE);

        // Reset forces the handshake outputs low without waiting for a clock.
        if (!rst_n) begin
            stall_o       = 1'b0;
            rdata_o       = '0;
            rdata_valid_o = 1'b0;
        end
    end

    assign led_o      = led_q;
    assign seg_data_o = seg_q;

endmodule

// File: doc/io_access_ctrl.md
Name: io_access_ctrl

Overview:
Sequences CPU accesses to the board I/O space: switch reads gated by the confirm button, confirm-status reads, and LED and seven-segment register writes. It sits between the EX/MEM-stage I/O control signals and the physical switches, button, LEDs and display. It stalls the pipeline while a switch read waits for the user to press and release confirm, then returns the switch data to the register-file write path.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive stable cycles before the debounced button level changes (2 ms at 100 MHz).
SW_ADDR, 14'h3C70, switch data read address.
CONF_ADDR, 14'h3C80, confirm status read address.
LED_ADDR, 14'h3C60, LED register write address.
SEG_ADDR, 14'h3C90, seven-segment data register write address.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
req_valid_i  in  1  I/O request present this cycle.
io_read_i  in  1  I/O read.
io_write_i  in  1  I/O write.
addr_i  in  14  I/O address.
wdata_i  in  32  write data from the register file.
byte_or_word_i  in  2  00 signed byte, 01 word, 10 unsigned byte, 11 unsigned halfword.
confirm_btn_i  in  1  raw confirm button, asynchronous to clk.
switch_i  in  16  raw switches.
stall_o  out  1  freeze the pipeline.
rdata_o  out  32  read data to the register-file write path.
rdata_valid_o  out  1  rdata_o valid this cycle.
led_o  out  16  LED register.
seg_data_o  out  32  seven-segment data register.
confirm_o  out  1  debounced confirm level.

Behaviour:
- Reset (asynchronous, active low): FSM in IDLE; led_o, seg_data_o, confirm_o, latched switch data and the debounce counter all 0. stall_o=0 and rdata_valid_o=0 while in reset.
- Debounce: confirm_btn_i passes through a 2-FF synchronizer. The counter increments while the synchronized value differs from confirm_o and clears when it matches. When the count reaches DEBOUNCE_CYCLES-1, confirm_o toggles and the counter clears.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: a switch read (req_valid_i & io_read_i & !io_write_i & addr_i==SW_ADDR) moves to WAIT_PRESS.
  - WAIT_PRESS: on a confirm_o rising edge, latch the extended switch_i and move to WAIT_RELEASE.
  - WAIT_RELEASE: on a confirm_o falling edge, move to DONE.
  - DONE: return to IDLE unconditionally.
  - If req_valid_i drops in WAIT_PRESS or WAIT_RELEASE, return to IDLE next cycle with no rdata_valid_o.
  - If confirm_o is already 1 when a switch read arrives, wait for release, then a fresh press.
- stall_o (combinational) = switch-read request & state!=DONE. It rises in the same cycle as the request and is 0 in DONE, so the pipeline advances exactly once.
- Switch read data: rdata_o = latched value in DONE and rdata_valid_o=1 for that one cycle. Extension by byte_or_word_i:
  - 01: sign-extend switch[15:0].
  - 00: sign-extend switch[7:0].
  - 10: zero-extend switch[7:0].
  - 11: zero-extend switch[15:0].
- CONF_ADDR read: single cycle, no stall. rdata_o={31'b0,confirm_o}, rdata_valid_o=1 combinationally.
- Unmapped read: single cycle, rdata_o=0, rdata_valid_o=1.
- When rdata_valid_o=0, rdata_o=0.
- Writes: single cycle, no stall, registered at the clk edge.
  - LED_ADDR: word or halfword (01/11) loads wdata_i[15:0]; byte (00/10) loads led_o[7:0] only and holds [15:8].
  - SEG_ADDR: 01 loads the full 32 bits; 11 loads [15:0]; byte loads [7:0]; remaining bits hold.
  - Unmapped write: ignored.
- io_read_i & io_write_i together: the write is performed, the read is ignored, no stall, rdata_valid_o=0.
- Writes are not accepted outside IDLE; the pipeline is stalled, so none should arrive.
- Reset mid-wait: immediate return to IDLE, stall_o drops asynchronously, latched data cleared.

Decomposition:
- Shared package io_map_pkg: the address constants, the byte_or_word encodings (BW_SBYTE, BW_WORD, BW_UBYTE, BW_UHALF) and the FSM state typedef.
- Sub-module btn_debounce (synchronizer, counter, confirm_o, rise/fall strobes), parameterized by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then write LED_ADDR word wdata=32'h0000A5A5 -> led_o=16'hA5A5 next edge; byte write 32'h3C -> led_o=16'hA53C; stall_o never 1.
2. Switch read word, switch_i=16'h8001, then press and release confirm (each held 10 cycles) -> stall_o=1 from the request cycle until DONE; one cycle of rdata_valid_o=1 with rdata_o=32'hFFFF8001.
3. Same sequence with byte_or_word_i=10 and switch_i=16'h80F0 -> rdata_o=32'h000000F0. With 00 -> rdata_o=32'hFFFFFFF0.
4. Button bounce of 2-cycle pulses, shorter than DEBOUNCE_CYCLES, during WAIT_PRESS -> confirm_o unchanged, FSM stays in WAIT_PRESS, stall_o held at 1.
5. CONF_ADDR read while the button has been held stable for 6 cycles -> same-cycle rdata_o=1, rdata_valid_o=1, stall_o=0.
6. Assert rst_n=0 in WAIT_RELEASE -> stall_o=0 immediately, led_o=0, seg_data_o=0; after release, a new switch read restarts in WAIT_PRESS.
